// File: rtl/jstk_spi_xfer.sv
// ============================================================================
//  Module   : jstk_spi_xfer
//  Purpose  : SPI mode-0 master for the PmodJSTK. Each rising edge of the slow
//             SNDREC clock starts one 5-byte transaction. Byte 0 carries the
//             LED command (DIN) and bytes 1-4 send 0x00. All 5 received bytes
//             are presented together on DOUT with a one-cycle DONE pulse.
//  Options  : define JSTK_XFER_CNT_EN to add the XFER_CNT completed-transfer
//             counter output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jstk_spi_xfer #(
  parameter int SCLK_HALF = 50,   // CLK cycles per SCLK half-period
  parameter int GAP_CYC   = 1500  // SS-to-first-SCLK setup and inter-byte gap
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNDREC,
  input  logic [7:0]  DIN,
  input  logic        MISO,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  output logic [39:0] DOUT,
  output logic        BUSY,
  output logic        DONE
`ifdef JSTK_XFER_CNT_EN
  ,
  output logic [15:0] XFER_CNT
`endif
);

  // One shared down-time counter serves both the gap/setup hold and the SCLK
  // half-period, so it is sized for the larger of the two.
  localparam int MAX_CNT = (GAP_CYC > SCLK_HALF) ? GAP_CYC : SCLK_HALF;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [39:0]   rx_buf_q, rx_buf_d;
  logic [39:0]   dout_q, dout_d;
  logic          ss_q, ss_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          snd_edge;
`ifdef JSTK_XFER_CNT_EN
  logic [15:0]   xfer_cnt_q, xfer_cnt_d;
`endif

  // Rising edge of the synchronised SNDREC (first stage high, second low).
  assign snd_edge = sync_q[0] & ~sync_q[1];

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], SNDREC};
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_buf_d   = rx_buf_q;
    dout_d     = dout_q;
    ss_d       = ss_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef JSTK_XFER_CNT_EN
    xfer_cnt_d = xfer_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Edges arriving in any other state are simply ignored.
        if (snd_edge) begin
          tx_sh_d    = DIN;
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          byte_cnt_d = 3'd0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = 3'd0;
          mosi_d    = tx_sh_q[7];
          state_d   = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: capture the slave's bit.
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], MISO};
          end else begin
            // Falling SCLK: either advance to the next bit or close the byte.
            sclk_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              byte_cnt_d = byte_cnt_q + 1'b1;
              rx_buf_d   = {rx_buf_q[31:0], rx_sh_q};
              mosi_d     = 1'b0;
              if (byte_cnt_q == 3'd4) begin
                // Final byte: publish the whole frame at once.
                dout_d  = {rx_buf_q[31:0], rx_sh_q};
                done_d  = 1'b1;
`ifdef JSTK_XFER_CNT_EN
                xfer_cnt_d = xfer_cnt_q + 16'd1;
`endif
                state_d = ST_FINISH;
              end else begin
                state_d = ST_GAP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_sh_d   = {tx_sh_q[6:0], 1'b0};
              mosi_d    = tx_sh_q[6];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        sclk_d  = 1'b0;
        tx_sh_d = 8'h00;
        if (cnt_q == GAP_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = 3'd0;
          mosi_d    = 1'b0;  // bytes 1-4 always transmit zero
          state_d   = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FINISH: begin
        // DONE is high in this cycle with BUSY still asserted; SCLK is low.
        ss_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset releases SS immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sync_q     <= 2'b00;
      cnt_q      <= '0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 3'd0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      rx_buf_q   <= 40'h0;
      dout_q     <= 40'h0;
      ss_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef JSTK_XFER_CNT_EN
      xfer_cnt_q <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_buf_q   <= rx_buf_d;
      dout_q     <= dout_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef JSTK_XFER_CNT_EN
      xfer_cnt_q <= xfer_cnt_d;
`endif
    end
  end

  assign SS   = ss_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign DOUT = dout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
`ifdef JSTK_XFER_CNT_EN
  assign XFER_CNT = xfer_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jstk_spi_xfer.sv
// ============================================================================
//  Module   : tb_jstk_spi_xfer
//  Purpose  : Self-checking bench for jstk_spi_xfer. A PmodJSTK slave model
//             answers each transaction; expected MOSI bytes and DOUT frames
//             are queued when a transaction is launched and compared when the
//             slave/DONE monitor observes them. Honours JSTK_XFER_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jstk_spi_xfer;

  localparam int H = 4;
  localparam int G = 10;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SNDREC;
  logic [7:0]  DIN;
  logic        MISO = 1'b0;
  logic        SS;
  logic        SCLK;
  logic        MOSI;
  logic [39:0] DOUT;
  logic        BUSY;
  logic        DONE;
`ifdef JSTK_XFER_CNT_EN
  logic [15:0] XFER_CNT;
`endif

  jstk_spi_xfer #(
    .SCLK_HALF (H),
    .GAP_CYC   (G)
  ) u_dut (
    .CLK    (CLK),
    .RST    (RST),
    .SNDREC (SNDREC),
    .DIN    (DIN),
    .MISO   (MISO),
    .SS     (SS),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .DOUT   (DOUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
`ifdef JSTK_XFER_CNT_EN
    ,
    .XFER_CNT (XFER_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues and slave response table
  logic [7:0]  exp_mosi[$];
  logic [39:0] exp_dout[$];
  logic [7:0]  slv_bytes[5];

  // Slave model / protocol monitor state
  int          cyc = 0;
  int          done_cnt = 0;
  int          ss_falls = 0;
  int          ss_fall_cyc = 0;
  int          last_rise = 0;
  int          last_fall = 0;
  int          s_idx = 0;
  int          s_nbits = 0;
  bit          first_rise = 1'b0;
  logic        ss_p = 1'b1;
  logic        sclk_p = 1'b0;
  logic [7:0]  s_rx = 8'h00;
  logic [39:0] exp_frame;
  logic [7:0]  exp_byte;
`ifdef JSTK_XFER_CNT_EN
  logic [15:0] exp_xfers = 16'h0000;
`endif

  // Slave model and protocol/DONE monitor, sampled on the inactive edge.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      MISO       = 1'b0;
      s_idx      = 0;
      s_nbits    = 0;
      first_rise = 1'b0;
      ss_p       = SS;
      sclk_p     = SCLK;
`ifdef JSTK_XFER_CNT_EN
      exp_xfers  = 16'h0000;
`endif
    end else begin
      if (SS != ss_p) begin
        check_eq("ss_toggle_sclk_low", {39'd0, SCLK}, 40'd0);
        if (!SS) begin
          ss_falls++;
          ss_fall_cyc = cyc;
          first_rise  = 1'b1;
          s_idx       = 0;
          s_nbits     = 0;
          MISO        = slv_bytes[0][7];
        end
      end
      if (SCLK && !sclk_p) begin
        if (first_rise) begin
          check_eq("ss_to_first_sclk_ge_gap", {39'd0, (cyc - ss_fall_cyc) >= G}, 40'd1);
          first_rise = 1'b0;
        end else if (s_nbits == 0) begin
          check_eq("interbyte_low_ge_gap", {39'd0, (cyc - last_fall) >= G}, 40'd1);
        end else begin
          check_eq("sclk_period", 40'(cyc - last_rise), 40'(2 * H));
        end
        last_rise = cyc;
        s_rx      = {s_rx[6:0], MOSI};
        s_nbits++;
        if (s_nbits == 8) begin
          check_eq("mosi_pending", {39'd0, exp_mosi.size() != 0}, 40'd1);
          if (exp_mosi.size() != 0) begin
            exp_byte = exp_mosi.pop_front();
            check_eq("mosi_byte", {32'd0, s_rx}, {32'd0, exp_byte});
          end
        end
      end
      if (!SCLK && sclk_p) begin
        last_fall = cyc;
        if (s_nbits == 8) begin
          s_idx++;
          s_nbits = 0;
          MISO = (s_idx < 5) ? slv_bytes[s_idx][7] : 1'b0;
        end else begin
          MISO = slv_bytes[s_idx][7 - s_nbits];
        end
      end
      if (DONE) begin
        done_cnt++;
        check_eq("busy_in_done_cycle", {39'd0, BUSY}, 40'd1);
        check_eq("dout_pending", {39'd0, exp_dout.size() != 0}, 40'd1);
        if (exp_dout.size() != 0) begin
          exp_frame = exp_dout.pop_front();
          check_eq("dout_frame", DOUT, exp_frame);
        end
`ifdef JSTK_XFER_CNT_EN
        exp_xfers = exp_xfers + 16'd1;
        check_eq("xfer_cnt", {24'd0, XFER_CNT}, {24'd0, exp_xfers});
`endif
      end
      ss_p   = SS;
      sclk_p = SCLK;
    end
  end

  // Launch one transaction and check the SS assertion latency.
  task automatic run_xfer(input logic [7:0] din, input logic [39:0] resp);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) slv_bytes[i] = resp[39 - 8*i -: 8];
    exp_mosi.push_back(din);
    for (int i = 0; i < 4; i++) exp_mosi.push_back(8'h00);
    exp_dout.push_back(resp);
    DIN    = din;
    SNDREC = 1'b1;
    @(negedge CLK);
    check_eq("ss_high_during_sync", {39'd0, SS}, 40'd1);
    @(negedge CLK);
    check_eq("ss_low_after_sync", {39'd0, SS}, 40'd0);
    check_eq("busy_after_edge", {39'd0, BUSY}, 40'd1);
    repeat (20) @(negedge CLK);
    SNDREC = 1'b0;
  endtask

  // Wait (bounded) for the next DONE pulse seen by the monitor.
  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done_cnt != start) break;
    end
    check_eq("done_seen", {39'd0, done_cnt != start}, 40'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int done_ref;
  int ss_ref;
  bit reached;

  initial begin
    RST    = 1'b1;
    SNDREC = 1'b0;
    DIN    = 8'h00;
    for (int i = 0; i < 5; i++) slv_bytes[i] = 8'h00;
    repeat (3) @(negedge CLK);
    check_eq("rst_ss",   {39'd0, SS},   40'd1);
    check_eq("rst_sclk", {39'd0, SCLK}, 40'd0);
    check_eq("rst_mosi", {39'd0, MOSI}, 40'd0);
    check_eq("rst_dout", DOUT,          40'd0);
    check_eq("rst_busy", {39'd0, BUSY}, 40'd0);
    check_eq("rst_done", {39'd0, DONE}, 40'd0);
`ifdef JSTK_XFER_CNT_EN
    check_eq("rst_xfer_cnt", {24'd0, XFER_CNT}, 40'd0);
`endif
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Basic transaction with the LED command byte
    done_ref = done_cnt;
    ss_ref   = ss_falls;
    run_xfer(8'h83, 40'hA1B2C3D4E5);
    wait_done(1500);
    repeat (5) @(negedge CLK);
    check_eq("t1_done_count", 40'(done_cnt - done_ref), 40'd1);
    check_eq("t1_ss_low_once", 40'(ss_falls - ss_ref), 40'd1);
    check_eq("t1_dout_hold", DOUT, 40'hA1B2C3D4E5);
    check_eq("t1_ss_idle", {39'd0, SS}, 40'd1);
    check_eq("t1_busy_idle", {39'd0, BUSY}, 40'd0);
    check_eq("t1_mosi_idle", {39'd0, MOSI}, 40'd0);

    // DIN change and extra SNDREC edges while busy have no effect
    done_ref = done_cnt;
    ss_ref   = ss_falls;
    run_xfer(8'hFF, 40'h123456789A);
    repeat (10) @(negedge CLK);
    DIN = 8'h00;
    repeat (2) begin
      SNDREC = 1'b1;
      repeat (6) @(negedge CLK);
      SNDREC = 1'b0;
      repeat (6) @(negedge CLK);
    end
    wait_done(1500);
    repeat (500) @(negedge CLK);
    check_eq("t2_single_done", 40'(done_cnt - done_ref), 40'd1);
    check_eq("t2_single_ss", 40'(ss_falls - ss_ref), 40'd1);
    check_eq("t2_idle_ss", {39'd0, SS}, 40'd1);
    check_eq("t2_dout_hold", DOUT, 40'h123456789A);

    // Reset during byte 2 aborts at once
    done_ref = done_cnt;
    run_xfer(8'h5A, 40'h0F1E2D3C4B);
    reached = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if (s_idx == 2 && s_nbits == 3) begin
        reached = 1'b1;
        break;
      end
    end
    check_eq("t3_abort_point", {39'd0, reached}, 40'd1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_eq("t3_ss_async", {39'd0, SS}, 40'd1);
    check_eq("t3_sclk_async", {39'd0, SCLK}, 40'd0);
    check_eq("t3_busy_async", {39'd0, BUSY}, 40'd0);
    check_eq("t3_dout_zero", DOUT, 40'd0);
    exp_mosi.delete();
    exp_dout.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("t3_no_done", 40'(done_cnt - done_ref), 40'd0);
    check_eq("t3_dout_still_zero", DOUT, 40'd0);

    // Restart after abort completes normally
    run_xfer(8'hC6, 40'h5566778899);
    wait_done(1500);
    repeat (5) @(negedge CLK);
    check_eq("t4_dout_hold", DOUT, 40'h5566778899);
    check_eq("t4_busy_idle", {39'd0, BUSY}, 40'd0);
    check_eq("mosi_queue_drained", 40'(exp_mosi.size()), 40'd0);
    check_eq("dout_queue_drained", 40'(exp_dout.size()), 40'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
